// File: rtl/pea_cmd_writer_pkg.sv
// Shared PEA command-token definitions: mode codes, command field layout and
// the packing helper used by both the writer and the consumer side.
package pea_cmd_writer_pkg;

   typedef enum logic [7:0] {
      MODE_STP = 8'd0,
      MODE_EVP = 8'd1,
      MODE_EVB = 8'd2,
      MODE_RST = 8'd3
   } mode_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CMD,
      S_DATA
   } state_e;

   localparam int CMD_BITS     = 16;
   localparam int CMD_MODE_LSB = 8;
   localparam int CMD_ARG1_LSB = 5;
   localparam int CMD_ARG2_LSB = 0;
   localparam int CNT_W        = 6;

   function automatic logic [CMD_BITS-1:0] pack_cmd(input logic [7:0] mode,
                                                    input logic [2:0] arg1,
                                                    input logic [4:0] arg2);
      logic [CMD_BITS-1:0] w;
      w = '0;
      w[CMD_MODE_LSB +: 8] = mode;
      w[CMD_ARG1_LSB +: 3] = arg1;
      w[CMD_ARG2_LSB +: 5] = arg2;
      return w;
   endfunction

endpackage

// File: rtl/pea_token_count.sv
// Data-token count per instruction; shared with the PEA consumer so both ends
// agree on how many tokens follow each command token.
module pea_token_count
   import pea_cmd_writer_pkg::*;
(
   input  logic [7:0]       mode,
   input  logic [4:0]       arg2,
   output logic [CNT_W-1:0] n,
   output logic             ok
);

   always_comb begin
      n  = '0;
      ok = 1'b1;
      case (mode)
         MODE_STP: n = {1'b0, arg2} + 6'd1;
         MODE_EVP: n = 6'd1;
         MODE_EVB: n = {1'b0, arg2};
         MODE_RST: n = '0;
         default:  ok = 1'b0;
      endcase
   end

endmodule

// File: rtl/pea_cmd_writer.sv
// PEA producer front end: reserves FIFO space for a whole instruction, writes
// its command token, then streams the instruction's data tokens from upstream.
module pea_cmd_writer
   import pea_cmd_writer_pkg::*;
#(
   parameter int word_size   = 16,
   parameter int buffer_size = 1024
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic [7:0]                     req_mode,
   input  logic [2:0]                     req_arg1,
   input  logic [4:0]                     req_arg2,
   input  logic                           din_valid,
   output logic                           din_ready,
   input  logic [word_size-1:0]           din,
   input  logic [$clog2(buffer_size)-1:0] command_free_space,
   input  logic [$clog2(buffer_size)-1:0] data_free_space,
   output logic                           command_wr_en,
   output logic [word_size-1:0]           command_wr_data,
   output logic                           data_wr_en,
   output logic [word_size-1:0]           data_wr_data,
   output logic                           busy,
   output logic                           err_mode
);

   state_e               state, state_nx;
   logic [CNT_W-1:0]     cnt, cnt_nx;
   logic [word_size-1:0] cmd_word;
   logic                 err_q;
   logic [CNT_W-1:0]     req_n;
   logic                 mode_ok;
   logic                 space_ok;
   logic                 req_fire;

   pea_token_count u_token_count (
      .mode (req_mode),
      .arg2 (req_arg2),
      .n    (req_n),
      .ok   (mode_ok)
   );

   // Whole-instruction reservation: the PEA never sees a partial instruction.
   assign space_ok = (command_free_space != '0) &&
                     (32'(data_free_space) >= 32'(req_n));

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      req_ready = 1'b0;
      din_ready = 1'b0;
      case (state)
         S_IDLE: begin
            // Unknown modes are drained without a space check so they cannot wedge.
            req_ready = !mode_ok || space_ok;
            if (req_valid && req_ready && mode_ok) begin
               state_nx = S_CMD;
               cnt_nx   = req_n;
            end
         end
         S_CMD: state_nx = (cnt != '0) ? S_DATA : S_IDLE;
         S_DATA: begin
            din_ready = 1'b1;
            if (din_valid) begin
               cnt_nx = cnt - 6'd1;
               if (cnt == 6'd1) state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign req_fire = req_valid && req_ready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         cmd_word <= '0;
         err_q    <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         err_q <= req_fire && !mode_ok;
         if (req_fire && mode_ok)
            cmd_word <= word_size'(pack_cmd(req_mode, req_arg1, req_arg2));
      end
   end

   assign command_wr_en   = (state == S_CMD);
   assign command_wr_data = cmd_word;
   assign data_wr_en      = din_valid && din_ready;
   assign data_wr_data    = din;
   assign busy            = (state != S_IDLE);
   assign err_mode        = err_q;

endmodule
